// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, round constants, xtime and key-schedule types.
// Used by rnd_key_gen (optional RND_KEY_CACHE_EN build) and sub_word.
package aes_pkg;

  typedef logic [127:0] aes_block_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } key_gen_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // GF(2^8) multiply by x, reduced by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word (also shared with SubBytes).
module sub_word
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    assign o_word[gi*8 +: 8] = SBOX[i_word[gi*8 +: 8]];
  end

endmodule

// File: rtl/rnd_key_gen.sv
// AES-128 key-schedule engine: one round key per valid/ready handshake.
// Optional RND_KEY_CACHE_EN keeps the emitted schedule and replays it on reuse.
module rnd_key_gen
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  aes_block_t key_in,
  input  logic       reuse,
  input  logic       key_ready,
  output aes_block_t rnd_key,
  output logic [3:0] rnd_idx,
  output logic       key_valid,
  output logic       busy,
  output logic       done
);

  key_gen_state_t r_state, w_state_next;
  aes_block_t     r_key;
  logic [3:0]     r_idx;
  logic [7:0]     r_rcon;
  logic           r_valid, r_done;

  logic [31:0] w_w0, w_w1, w_w2, w_w3, w_rot, w_sub;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;
  logic        w_hs, w_last, w_launch, w_reuse_ok;

  assign {w_w0, w_w1, w_w2, w_w3} = r_key;
  assign w_rot = {w_w3[23:0], w_w3[31:24]};

  sub_word u_sub_word (
    .i_word(w_rot),
    .o_word(w_sub)
  );

  assign w_n0   = w_w0 ^ w_sub ^ {r_rcon, 24'h0};
  assign w_n1   = w_w1 ^ w_n0;
  assign w_n2   = w_w2 ^ w_n1;
  assign w_n3   = w_w3 ^ w_n2;
  assign w_hs   = r_valid & key_ready;
  assign w_last = (r_idx == 4'(NR));

`ifdef RND_KEY_CACHE_EN
  aes_block_t r_cache [NR+1];
  logic       r_cache_vld, r_replay, w_reuse_go;

  assign w_reuse_ok = reuse & r_cache_vld;
  assign w_reuse_go = (r_state == IDLE) & ~start & w_reuse_ok;

  // Only freshly computed keys are written; a replay leaves the array untouched.
  always_ff @(posedge CLK) begin
    if (w_hs && !r_replay) r_cache[r_idx] <= r_key;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cache_vld <= 1'b0;
      r_replay    <= 1'b0;
    end else if (w_launch) begin
      r_cache_vld <= 1'b0;
      r_replay    <= 1'b0;
    end else if (w_reuse_go) begin
      r_replay <= 1'b1;
    end else if (w_hs && w_last) begin
      r_cache_vld <= 1'b1;
    end
  end
`else
  logic w_unused_reuse;
  assign w_unused_reuse = reuse;
  assign w_reuse_ok     = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_launch     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = RUN;
          w_launch     = 1'b1;
        end else if (w_reuse_ok) begin
          w_state_next = RUN;
        end
      end
      RUN:     if (w_hs && w_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // The cycle after launch only raises key_valid, giving the one-cycle start latency.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_key   <= '0;
      r_idx   <= '0;
      r_rcon  <= RCON[0];
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_launch) begin
        r_key   <= key_in;
        r_idx   <= '0;
        r_rcon  <= RCON[0];
        r_valid <= 1'b0;
`ifdef RND_KEY_CACHE_EN
      end else if (w_reuse_go) begin
        r_key   <= r_cache[0];
        r_idx   <= '0;
        r_rcon  <= RCON[0];
        r_valid <= 1'b0;
`endif
      end else if (r_state == RUN) begin
        if (!r_valid) begin
          r_valid <= 1'b1;
        end else if (w_hs) begin
          if (w_last) begin
            r_valid <= 1'b0;
            r_done  <= 1'b1;
          end else begin
`ifdef RND_KEY_CACHE_EN
            r_key <= r_replay ? r_cache[r_idx + 4'd1] : {w_n0, w_n1, w_n2, w_n3};
`else
            r_key <= {w_n0, w_n1, w_n2, w_n3};
`endif
            r_idx  <= r_idx + 4'd1;
            r_rcon <= xtime(r_rcon);
          end
        end
      end
    end
  end

  assign rnd_key   = r_key;
  assign rnd_idx   = r_idx;
  assign key_valid = r_valid;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;

endmodule
